// File: rtl/output_wrapper_pkg.sv
// ============================================================================
// Module : output_wrapper_pkg
// Brief  : State encodings and default sizes for the word-serial link.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package output_wrapper_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_N_WORDS = 4;
  localparam int DEF_CNT_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_PRESENT = 3'd2,
    ST_RELEASE = 3'd3,
    ST_ADVANCE = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/output_wrapper_if.sv
// ============================================================================
// Module : output_wrapper_if
// Brief  : 4-phase data_ready/data_accepted word link between tx and acceptor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface output_wrapper_if #(
  parameter int DATA_W = 16
) ();

  logic [DATA_W-1:0] data_out;
  logic              data_ready;
  logic              data_accepted;

  modport master (
    output data_out,
    output data_ready,
    input  data_accepted
  );

  modport slave (
    input  data_out,
    input  data_ready,
    output data_accepted
  );

endinterface

`default_nettype wire

// File: rtl/output_wrapper_cu.sv
// ============================================================================
// Module : output_wrapper_cu
// Brief  : Control FSM of the transmit wrapper; all outputs are registered.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module output_wrapper_cu
  import output_wrapper_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic done_rise,
  input  logic data_accepted,
  input  logic co,
  output logic load_buf,
  output logic data_ready,
  output logic empty_buffer,
  output logic InzCnt,
  output logic IncCnt
);

  state_t r_state;

  // Outputs are set on the edge that enters the state they belong to, so
  // the strobes are high during CAPTURE / ADVANCE and act at their end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      load_buf     <= 1'b0;
      data_ready   <= 1'b0;
      empty_buffer <= 1'b1;
      InzCnt       <= 1'b0;
      IncCnt       <= 1'b0;
    end else begin
      load_buf <= 1'b0;
      InzCnt   <= 1'b0;
      IncCnt   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (done_rise) begin
            r_state      <= ST_CAPTURE;
            empty_buffer <= 1'b0;
            load_buf     <= 1'b1;
            InzCnt       <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          r_state    <= ST_PRESENT;
          data_ready <= 1'b1;
        end
        ST_PRESENT: begin
          if (data_accepted) begin
            r_state    <= ST_RELEASE;
            data_ready <= 1'b0;
          end
        end
        ST_RELEASE: begin
          // cnt is frozen here, so co already tells what ADVANCE will do
          if (!data_accepted) begin
            r_state <= ST_ADVANCE;
            if (co) InzCnt <= 1'b1;
            else    IncCnt <= 1'b1;
          end
        end
        ST_ADVANCE: begin
          if (co) begin
            r_state      <= ST_IDLE;
            empty_buffer <= 1'b1;
          end else begin
            r_state    <= ST_PRESENT;
            data_ready <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          data_ready   <= 1'b0;
          empty_buffer <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/output_wrapper.sv
// ============================================================================
// Module : output_wrapper
// Brief  : Captures an N-word core result and sends it word by word over the link.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module output_wrapper
  import output_wrapper_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int N_WORDS = DEF_N_WORDS,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Done,
  input  logic [DATA_W*N_WORDS-1:0] result_in,
  output_wrapper_if.master          link,
  output logic                      empty_buffer
);

  logic              r_done_q;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_buf   [N_WORDS];
  logic [DATA_W-1:0] w_words [N_WORDS];

  logic w_done_rise;
  logic w_co;
  logic w_load_buf;
  logic w_inz_cnt;
  logic w_inc_cnt;

  assign w_done_rise = Done & ~r_done_q;
  assign w_co        = (r_cnt == CNT_W'(N_WORDS - 1));

  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_unpack
    assign w_words[gi] = result_in[gi*DATA_W +: DATA_W];
  end

  // done_q resets high so a Done level held through reset is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_q <= 1'b1;
      r_cnt    <= '0;
      for (int i = 0; i < N_WORDS; i++) r_buf[i] <= '0;
    end else begin
      r_done_q <= Done;
      if (w_load_buf) begin
        for (int i = 0; i < N_WORDS; i++) r_buf[i] <= w_words[i];
      end
      if (w_inz_cnt)      r_cnt <= '0;
      else if (w_inc_cnt) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign link.data_out = r_buf[r_cnt];

  output_wrapper_cu u_cu (
    .clk           (clk),
    .rst           (rst),
    .done_rise     (w_done_rise),
    .data_accepted (link.data_accepted),
    .co            (w_co),
    .load_buf      (w_load_buf),
    .data_ready    (link.data_ready),
    .empty_buffer  (empty_buffer),
    .InzCnt        (w_inz_cnt),
    .IncCnt        (w_inc_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_output_wrapper.sv
// ============================================================================
// Module : tb_output_wrapper
// Brief  : Self-checking bench for output_wrapper (table, corner and random frames).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_output_wrapper;

  logic        clk = 1'b0;
  logic        rst;
  logic        Done;
  logic [63:0] result_in;
  logic        empty_buffer;

  output_wrapper_if #(.DATA_W(16)) link ();

  output_wrapper #(.DATA_W(16), .N_WORDS(4), .CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .Done         (Done),
    .result_in    (result_in),
    .link         (link),
    .empty_buffer (empty_buffer)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q [$];

  typedef struct {
    logic [63:0]      res;
    int               dly;
    int               hold_word;
    int               hold_cyc;
    int               pulse_word;
    logic [3:0][15:0] exp;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // bounded wait on data_ready; a timeout shows up as a failed compare
  task automatic wait_dr(input logic val, input string nm);
    int n = 0;
    while (link.data_ready !== val && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(nm, {63'd0, link.data_ready}, {63'd0, val});
  endtask

  task automatic run_frame(input logic [63:0] res, input int dly, input int hold_word,
                           input int hold_cyc, input int pulse_word, input int abort_word);
    logic [15:0] w;
    result_in = res;
    Done = 1'b0;
    @(negedge clk);
    Done = 1'b1;
    @(negedge clk);
    check("capture_dr", {63'd0, link.data_ready}, 64'd0);
    check("capture_empty", {63'd0, empty_buffer}, 64'd0);
    @(negedge clk);
    check("first_dr", {63'd0, link.data_ready}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      wait_dr(1'b1, "word_ready");
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check($sformatf("word%0d", k), {48'd0, link.data_out}, {48'd0, w});
      if (k == abort_word) begin
        rst = 1'b1;
        @(negedge clk);
        check("abort_dr", {63'd0, link.data_ready}, 64'd0);
        check("abort_empty", {63'd0, empty_buffer}, 64'd1);
        check("abort_dout", {48'd0, link.data_out}, 64'd0);
        rst = 1'b0;
        exp_q.delete();
        return;
      end
      if (k == pulse_word) begin
        Done = 1'b0;
        result_in = ~res;
        @(negedge clk);
        Done = 1'b1;
        @(negedge clk);
        check("pulse_dr", {63'd0, link.data_ready}, 64'd1);
        check("pulse_dout", {48'd0, link.data_out}, {48'd0, w});
      end
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        check("hold_dr", {63'd0, link.data_ready}, 64'd1);
        check("stable_present", {48'd0, link.data_out}, {48'd0, w});
      end
      link.data_accepted = 1'b1;
      @(negedge clk);
      wait_dr(1'b0, "release_dr");
      check("stable_release", {48'd0, link.data_out}, {48'd0, w});
      if (k == hold_word) begin
        for (int h = 0; h < hold_cyc; h++) begin
          @(negedge clk);
          check("stall_dr", {63'd0, link.data_ready}, 64'd0);
          check("stall_dout", {48'd0, link.data_out}, {48'd0, w});
        end
      end
      for (int d = 0; d < dly; d++) @(negedge clk);
      link.data_accepted = 1'b0;
      @(negedge clk);
      if (k == 3) begin
        check("last_advance_empty", {63'd0, empty_buffer}, 64'd0);
        @(negedge clk);
        check("frame_done_empty", {63'd0, empty_buffer}, 64'd1);
      end
    end
    // Done stays high: there must be no second capture
    repeat (3) @(negedge clk);
    check("idle_dr", {63'd0, link.data_ready}, 64'd0);
    check("idle_empty", {63'd0, empty_buffer}, 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    int dr_cnt;
    logic [15:0] seen;
    logic [3:0][15:0] t6;

    tbl[0] = '{64'h4444_3333_2222_1111, 1, -1,  0, -1, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    tbl[1] = '{64'h4444_3333_2222_1111, 1,  2, 10, -1, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    tbl[2] = '{64'h4444_3333_2222_1111, 1, -1,  0,  1, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    tbl[3] = '{64'hDEAD_BEEF_0000_FFFF, 0, -1,  0, -1, {16'hDEAD, 16'hBEEF, 16'h0000, 16'hFFFF}};
    tbl[4] = '{64'h8001_7FFE_A5A5_5A5A, 3,  0,  2,  3, {16'h8001, 16'h7FFE, 16'hA5A5, 16'h5A5A}};

    // reset with Done held high
    rst = 1'b1;
    Done = 1'b1;
    result_in = 64'h4444_3333_2222_1111;
    link.data_accepted = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_dr", {63'd0, link.data_ready}, 64'd0);
      check("rst_empty", {63'd0, empty_buffer}, 64'd1);
      check("rst_dout", {48'd0, link.data_out}, 64'd0);
    end

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(tbl[i].exp[k]);
      run_frame(tbl[i].res, tbl[i].dly, tbl[i].hold_word, tbl[i].hold_cyc,
                tbl[i].pulse_word, -1);
    end

    // reset while word 2 is presented, then a fresh frame from word 0
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222); exp_q.push_back(16'h3333);
    run_frame(64'h4444_3333_2222_1111, 1, -1, 0, -1, 2);
    repeat (3) @(negedge clk);
    check("post_rst_no_capture", {63'd0, link.data_ready}, 64'd0);
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333); exp_q.push_back(16'h4444);
    run_frame(64'h4444_3333_2222_1111, 0, -1, 0, -1, -1);

    // acceptor tied high: one-cycle data_ready per word, stall in RELEASE
    t6 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    link.data_accepted = 1'b1;
    result_in = 64'h4444_3333_2222_1111;
    Done = 1'b0;
    @(negedge clk);
    Done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dr_cnt = 0;
      seen = 16'h0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (link.data_ready === 1'b1) begin
          dr_cnt++;
          seen = link.data_out;
        end
      end
      check($sformatf("tied_dr_cycles%0d", k), 64'(dr_cnt), 64'd1);
      check($sformatf("tied_word%0d", k), {48'd0, seen}, {48'd0, t6[k]});
      check("tied_stall_empty", {63'd0, empty_buffer}, 64'd0);
      link.data_accepted = 1'b0;
      @(negedge clk);
      link.data_accepted = 1'b1;
    end
    link.data_accepted = 1'b0;
    repeat (3) @(negedge clk);
    check("tied_done_empty", {63'd0, empty_buffer}, 64'd1);

    // random frames against the word-queue model
    for (int n = 0; n < 8; n++) begin
      r = {$urandom, $urandom};
      for (int k = 0; k < 4; k++) exp_q.push_back(r[k*16 +: 16]);
      run_frame(r, int'($urandom_range(0, 2)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1,
                int'($urandom_range(1, 4)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
